// File: rtl/core_bus_pkg.sv
// Shared core-bus types and constants: bus widths, default instruction/data windows,
// read encoding of the byte-lane enables and the read-response record.
package core_bus_pkg;

  localparam int DATA_W = 32;
  localparam int WEN_W  = 4;

  localparam logic [31:0] INST_BASE = 32'h0000_0000;
  localparam logic [31:0] INST_LEN  = 32'h0001_0000;
  localparam logic [31:0] DATA_BASE = 32'hFFFF_1000;
  localparam logic [31:0] DATA_LEN  = 32'h0000_1000;

  localparam logic [WEN_W-1:0] WEN_READ = 4'b0000;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/core_bus_sram_be.sv
// Byte-enable word array: one shared address, per-lane write, registered (synchronous) read.
// Storage is never reset so it maps onto block RAM.
module core_bus_sram_be
  import core_bus_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              CLK,
  input  logic              re_i,
  input  logic [WEN_W-1:0]  wen_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge CLK) begin
    for (int i = 0; i < WEN_W; i++) begin
      if (wen_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/core_bus_mem_responder.sv
// Data-memory slave on the core bus: window decode, byte-lane writes, fixed-latency read responses.
// Optional accepted-read/write counters are built when MEM_RESP_STATS_EN is defined.
module core_bus_mem_responder
  import core_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DATA_BASE,
  parameter logic [31:0] SIZE_BYTES = DATA_LEN,
  parameter int          LATENCY    = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              mem_en,
  input  logic [WEN_W-1:0]  mem_wen,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rvld,
  output logic              mem_err,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  localparam int DEPTH = int'(SIZE_BYTES >> 2);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]       offset;
  logic              in_win;
  logic              is_read;
  logic              accept;
  logic [WEN_W-1:0]  sram_wen;
  logic              sram_re;
  logic [DATA_W-1:0] sram_rdata;
  logic              s0_vld_q;
  logic              s0_err_q;
  resp_t             stage0;
  resp_t             resp_out;

  // Wrapping subtraction turns "below base" into a huge offset, so one compare covers both edges.
  assign offset   = mem_addr - BASE_ADDR;
  assign in_win   = offset < SIZE_BYTES;
  assign is_read  = (mem_wen == WEN_READ);
  assign accept   = mem_en && !RST;
  assign sram_re  = accept && is_read && in_win;
  assign sram_wen = (accept && !is_read && in_win) ? mem_wen : WEN_READ;

  core_bus_sram_be #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .CLK     (CLK),
    .re_i    (sram_re),
    .wen_i   (sram_wen),
    .addr_i  (offset[AW+1:2]),
    .wdata_i (mem_wdata),
    .rdata_o (sram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_vld_q <= 1'b0;
      s0_err_q <= 1'b0;
    end else begin
      s0_vld_q <= accept && is_read;
      s0_err_q <= accept && is_read && !in_win;
    end
  end

  // The RAM output register is the data half of the first stage; err forces the data to zero.
  always_comb begin
    stage0      = '0;
    stage0.vld  = s0_vld_q;
    stage0.err  = s0_err_q;
    stage0.data = s0_err_q ? '0 : sram_rdata;
  end

  generate
    if (LATENCY <= 1) begin : g_lat1
      assign resp_out = stage0;
    end else begin : g_pipe
      resp_t pipe_q [LATENCY-1];

      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int i = 0; i < LATENCY-1; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q[0] <= stage0;
          for (int i = 1; i < LATENCY-1; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign resp_out = pipe_q[LATENCY-2];
    end
  endgenerate

  assign mem_rvld  = resp_out.vld;
  assign mem_err   = resp_out.vld && resp_out.err;
  assign mem_rdata = resp_out.vld ? resp_out.data : '0;

`ifdef MEM_RESP_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (accept) begin
      if (is_read && (rd_cnt_q != 32'hFFFF_FFFF)) begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
      if (!is_read && (wr_cnt_q != 32'hFFFF_FFFF)) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = 32'h0;
  assign wr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_core_bus_mem_responder.sv
// Directed, table-driven bench for core_bus_mem_responder (LATENCY=4) with a small response scoreboard.
module tb_core_bus_mem_responder;

  localparam int LAT = 4;

  logic        CLK;
  logic        RST;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvld;
  logic        mem_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  core_bus_mem_responder #(
    .BASE_ADDR  (32'hFFFF_1000),
    .SIZE_BYTES (32'h0000_1000),
    .LATENCY    (LAT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rvld  (mem_rvld),
    .mem_err   (mem_err),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_vld;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  // Expected responses in flight; index 0 = request accepted at the most recent edge.
  logic        ev [LAT];
  logic        ee [LAT];
  logic [31:0] ed [LAT];
  string       en_name [LAT];
  logic [31:0] exp_rd;
  logic [31:0] exp_wr;

  int tests;
  int fails;

  function automatic vec_t mk(string n, logic rst, logic en, logic [3:0] wen, logic [31:0] a,
                              logic [31:0] d, logic xv, logic xe, logic [31:0] xd);
    vec_t v;
    v.name = n; v.rst = rst; v.en = en; v.wen = wen; v.addr = a; v.wdata = d;
    v.exp_vld = xv; v.exp_err = xe; v.exp_rdata = xd;
    return v;
  endfunction

  function automatic vec_t rd(string n, logic [31:0] a, logic [31:0] xd);
    return mk(n, 1'b0, 1'b1, 4'h0, a, 32'h0, 1'b1, 1'b0, xd);
  endfunction

  function automatic vec_t rd_oob(string n, logic [31:0] a);
    return mk(n, 1'b0, 1'b1, 4'h0, a, 32'h0, 1'b1, 1'b1, 32'h0);
  endfunction

  function automatic vec_t wr(string n, logic [31:0] a, logic [3:0] wen, logic [31:0] d);
    return mk(n, 1'b0, 1'b1, wen, a, d, 1'b0, 1'b0, 32'h0);
  endfunction

  function automatic vec_t idle(string n);
    return mk(n, 1'b0, 1'b0, 4'hF, 32'hFFFF_1000, 32'h0, 1'b0, 1'b0, 32'h0);
  endfunction

  task automatic apply(input vec_t v);
    RST       = v.rst;
    mem_en    = v.en;
    mem_wen   = v.wen;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    @(posedge CLK);
    if (v.rst) begin
      for (int i = 0; i < LAT; i++) begin
        ev[i] = 1'b0; ee[i] = 1'b0; ed[i] = 32'h0; en_name[i] = "idle";
      end
      exp_rd = 32'h0;
      exp_wr = 32'h0;
    end else begin
      for (int i = LAT-1; i > 0; i--) begin
        ev[i] = ev[i-1]; ee[i] = ee[i-1]; ed[i] = ed[i-1]; en_name[i] = en_name[i-1];
      end
      ev[0] = v.en && v.exp_vld;
      ee[0] = v.en && v.exp_err;
      ed[0] = v.exp_rdata;
      en_name[0] = v.name;
`ifdef MEM_RESP_STATS_EN
      if (v.en && (v.wen == 4'h0) && (exp_rd != 32'hFFFF_FFFF)) exp_rd = exp_rd + 32'd1;
      if (v.en && (v.wen != 4'h0) && (exp_wr != 32'hFFFF_FFFF)) exp_wr = exp_wr + 32'd1;
`endif
    end
    @(negedge CLK);
    tests++;
    if (mem_rvld !== ev[LAT-1] || mem_err !== ee[LAT-1] || mem_rdata !== ed[LAT-1]) begin
      fails++;
      $display("[TB] FAIL resp[%s] got vld=%b err=%b rdata=%h, expected vld=%b err=%b rdata=%h",
               en_name[LAT-1], mem_rvld, mem_err, mem_rdata, ev[LAT-1], ee[LAT-1], ed[LAT-1]);
    end else if (ev[LAT-1]) begin
      $display("[TB] resp[%s] vld=1 err=%b rdata=%h", en_name[LAT-1], mem_err, mem_rdata);
    end
    tests++;
    if (rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
      fails++;
      $display("[TB] FAIL counters after %s got rd=%h wr=%h, expected rd=%h wr=%h",
               v.name, rd_cnt, wr_cnt, exp_rd, exp_wr);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < LAT; i++) apply(idle("drain"));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_rd = 32'h0;
    exp_wr = 32'h0;
    for (int i = 0; i < LAT; i++) begin
      ev[i] = 1'b0; ee[i] = 1'b0; ed[i] = 32'h0; en_name[i] = "idle";
    end
    RST = 1'b1; mem_en = 1'b0; mem_wen = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;

    // Main directed table
    vecs.push_back(mk("reset0", 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk("reset1", 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    vecs.push_back(wr("w_base_full", 32'hFFFF_1000, 4'hF, 32'hA5A5_1234));
    vecs.push_back(rd("r_base", 32'hFFFF_1000, 32'hA5A5_1234));
    vecs.push_back(wr("w_1004_full", 32'hFFFF_1004, 4'hF, 32'h1122_3344));
    vecs.push_back(wr("w_1004_0101", 32'hFFFF_1004, 4'b0101, 32'hFFFF_FFFF));
    vecs.push_back(rd("r_1004_lanes", 32'hFFFF_1004, 32'h11FF_33FF));
    for (int i = 0; i < 8; i++)
      vecs.push_back(wr($sformatf("w_blk%0d", i), 32'hFFFF_1100 + 32'(4*i), 4'hF, 32'hC0DE_0000 + 32'(i*32'h111)));
    for (int i = 0; i < 8; i++)
      vecs.push_back(rd($sformatf("r_blk%0d", i), 32'hFFFF_1100 + 32'(4*i), 32'hC0DE_0000 + 32'(i*32'h111)));
    vecs.push_back(wr("w_last", 32'hFFFF_1FFC, 4'hF, 32'h600D_F00D));
    vecs.push_back(rd("r_last", 32'hFFFF_1FFC, 32'h600D_F00D));
    vecs.push_back(rd_oob("r_oob_hi", 32'hFFFF_2000));
    vecs.push_back(rd_oob("r_oob_lo", 32'hFFFF_0FFC));
    vecs.push_back(wr("w_oob_hi", 32'hFFFF_2000, 4'hF, 32'hDEAD_BEEF));
    vecs.push_back(wr("w_oob_lo", 32'hFFFF_0FFC, 4'hF, 32'hDEAD_BEEF));
    vecs.push_back(rd("r_base_after_oob", 32'hFFFF_1000, 32'hA5A5_1234));
    vecs.push_back(rd("r_last_after_oob", 32'hFFFF_1FFC, 32'h600D_F00D));
    vecs.push_back(idle("idle_junk_wen"));
    vecs.push_back(rd("r_base_after_idle", 32'hFFFF_1000, 32'hA5A5_1234));
    vecs.push_back(wr("w_1008", 32'hFFFF_1008, 4'hF, 32'h0BAD_CAFE));
    vecs.push_back(rd("r_1008_next", 32'hFFFF_1008, 32'h0BAD_CAFE));
    vecs.push_back(rd("r_100B_lowbits", 32'hFFFF_100B, 32'h0BAD_CAFE));
    vecs.push_back(wr("w_base_lane3", 32'hFFFF_1000, 4'b1000, 32'h77FF_FFFF));
    vecs.push_back(rd("r_base_lane3", 32'hFFFF_1000, 32'h77A5_1234));

    foreach (vecs[i]) apply(vecs[i]);
    drain();

    // Reset while three reads are in flight: none may respond, then a fresh read works
    apply(rd("r_flight0", 32'hFFFF_1000, 32'h77A5_1234));
    apply(rd("r_flight1", 32'hFFFF_1004, 32'h11FF_33FF));
    apply(rd("r_flight2", 32'hFFFF_1008, 32'h0BAD_CAFE));
    apply(mk("rst_mid", 1'b1, 1'b1, 4'h0, 32'hFFFF_1000, 32'h0, 1'b0, 1'b0, 32'h0));
    drain();
    apply(rd("r_post_rst", 32'hFFFF_1004, 32'h11FF_33FF));
    drain();

`ifdef MEM_RESP_STATS_EN
    // Write counter saturation
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    exp_wr = 32'hFFFF_FFFF;
    apply(wr("w_sat", 32'hFFFF_1010, 4'hF, 32'h1234_5678));
    apply(rd("r_sat", 32'hFFFF_1010, 32'h1234_5678));
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
